rv_fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the RV32 core.
- Replaces the single-cycle PC register and next-PC mux with a decoupled fetch pipeline:
  - a PC generator,
  - a request/grant instruction-memory interface with multiple outstanding requests,
  - a prefetch FIFO feeding decode over valid/ready.
- Branch, jump, trap and mret targets arrive as one pre-prioritised redirect. The core resolves priority: trap > mret > jump/branch.

---
 rtl/rv_fetch_unit.sv | 123 ++++++++++++
 tb/tb_rv_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: decoupled RV32 fetch front end (PC generator, pipelined imem port, prefetch FIFO).
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module rv_fetch_unit #(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR    = '0,
    parameter int unsigned     FIFO_DEPTH      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            redirect_valid_in,
    input  logic [XLEN-1:0]                 redirect_pc_in,
    output logic                            imem_req_out,
    output logic [XLEN-1:0]                 imem_addr_out,
    input  logic                            imem_gnt_in,
    input  logic                            imem_rvalid_in,
    input  logic [31:0]                     imem_rdata_in,
    output logic                            inst_valid_out,
    output logic [31:0]                     inst_out,
    output logic [XLEN-1:0]                 inst_pc_out,
    input  logic                            inst_ready_in,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_out
);
    localparam int unsigned     AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned     CW      = AW + 1;
    localparam logic [CW:0]     DEPTH_C = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]   MAX_C   = CW'(MAX_OUTSTANDING);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   wr_ptr;
    logic [CW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW:0]     credit;
    logic [31:0]     data_q [FIFO_DEPTH];
    logic [XLEN-1:0] pc_q   [FIFO_DEPTH];
    logic            fifo_empty;
    logic            rsp_fire;
    logic            rsp_live;
    logic            issue;
    logic            push;
    logic            pop_fifo;

    assign count      = wr_ptr - rd_ptr;
    assign fifo_empty = (count == '0);
    assign rsp_fire   = imem_rvalid_in && (outstanding != '0);
    assign rsp_live   = rsp_fire && (drop_cnt == '0) && !redirect_valid_in;

    // Live in-flight responses plus stored entries must fit: each grant reserves a slot.
    assign credit       = {1'b0, outstanding - drop_cnt} + {1'b0, count};
    assign imem_req_out = !reset && !redirect_valid_in && (outstanding < MAX_C) && (credit < DEPTH_C);
    assign imem_addr_out  = fetch_pc;
    assign issue          = imem_req_out && imem_gnt_in;
    assign fifo_count_out = reset ? '0 : count;

    always_comb begin
        inst_valid_out = 1'b0;
        inst_out       = '0;
        inst_pc_out    = '0;
        if (!reset && !redirect_valid_in) begin
            if (!fifo_empty) begin
                inst_valid_out = 1'b1;
                inst_out       = data_q[rd_ptr[AW-1:0]];
                inst_pc_out    = pc_q[rd_ptr[AW-1:0]];
            end
`ifdef FETCH_BYPASS_EN
            else if (rsp_live) begin
                inst_valid_out = 1'b1;
                inst_out       = imem_rdata_in;
                inst_pc_out    = resp_pc;
            end
`endif
        end
    end

    assign pop_fifo = inst_valid_out && inst_ready_in && !fifo_empty;
`ifdef FETCH_BYPASS_EN
    assign push = rsp_live && !(fifo_empty && inst_ready_in);
`else
    assign push = rsp_live;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_VECTOR;
            resp_pc     <= RESET_VECTOR;
            outstanding <= '0;
            drop_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(rsp_fire);
            if (redirect_valid_in) begin
                fetch_pc <= redirect_pc_in;
                resp_pc  <= redirect_pc_in;
                drop_cnt <= outstanding - CW'(rsp_fire);
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + XLEN'(4);
                if (rsp_fire && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
                if (rsp_live)
                    resp_pc <= resp_pc + XLEN'(4);
                if (push)
                    wr_ptr <= wr_ptr + CW'(1);
                if (pop_fifo)
                    rd_ptr <= rd_ptr + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr[AW-1:0]] <= imem_rdata_in;
            pc_q[wr_ptr[AW-1:0]]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit: 1-cycle-latency memory model driven per cycle from tasks.
module tb_rv_fetch_unit;
    localparam logic [31:0] KEY = 32'h1357_9BDF;
`ifdef FETCH_BYPASS_EN
    localparam int          EXP_FIRST     = 1;
    localparam logic [2:0]  EXP_FIRST_CNT = 3'd0;
`else
    localparam int          EXP_FIRST     = 2;
    localparam logic [2:0]  EXP_FIRST_CNT = 3'd1;
`endif

    logic        clk;
    logic        reset;
    logic        redirect_valid_in;
    logic [31:0] redirect_pc_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] inst_pc_out;
    logic        inst_ready_in;
    logic [2:0]  fifo_count_out;

    rv_fetch_unit #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0000),
        .FIFO_DEPTH(4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .redirect_valid_in(redirect_valid_in),
        .redirect_pc_in(redirect_pc_in),
        .imem_req_out(imem_req_out),
        .imem_addr_out(imem_addr_out),
        .imem_gnt_in(imem_gnt_in),
        .imem_rvalid_in(imem_rvalid_in),
        .imem_rdata_in(imem_rdata_in),
        .inst_valid_out(inst_valid_out),
        .inst_out(inst_out),
        .inst_pc_out(inst_pc_out),
        .inst_ready_in(inst_ready_in),
        .fifo_count_out(fifo_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        gnt_en;
    logic        rsp_hold;
    logic [31:0] rsp_q[$];
    logic [31:0] grant_q[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];
    logic        obs_req;
    logic [31:0] obs_addr;
    logic        obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_inst;
    logic [2:0]  obs_count;

    // One clock cycle: present memory response/grant at negedge, sample just after, move on.
    task automatic tick();
        if (!rsp_hold && rsp_q.size() > 0) begin
            imem_rvalid_in = 1'b1;
            imem_rdata_in  = rsp_q.pop_front() ^ KEY;
        end else begin
            imem_rvalid_in = 1'b0;
            imem_rdata_in  = '0;
        end
        imem_gnt_in = gnt_en;
        #1;
        obs_req   = imem_req_out;
        obs_addr  = imem_addr_out;
        obs_valid = inst_valid_out;
        obs_pc    = inst_pc_out;
        obs_inst  = inst_out;
        obs_count = fifo_count_out;
        if (obs_req && imem_gnt_in) begin
            rsp_q.push_back(obs_addr);
            grant_q.push_back(obs_addr);
        end
        if (obs_valid && inst_ready_in) begin
            got_pc.push_back(obs_pc);
            got_inst.push_back(obs_inst);
        end
        @(negedge clk);
    endtask

    task automatic clear_logs();
        grant_q.delete();
        got_pc.delete();
        got_inst.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid_in = 1'b0;
        redirect_pc_in = '0;
        inst_ready_in = 1'b1;
        gnt_en = 1'b1;
        rsp_hold = 1'b0;
        rsp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (obs_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %0h expected 0", obs_req); end
        n_checks++; if (obs_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0h expected 0", obs_valid); end
        n_checks++; if (obs_count !== 3'd0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", obs_count); end
        n_checks++; if (obs_inst !== 32'h0) begin n_errors++; $display("FAIL reset_inst: got %h expected 0", obs_inst); end
        n_checks++; if (obs_pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h expected 0", obs_pc); end
    endtask

    task automatic test_stream();
        int first;
        logic [2:0] first_cnt;
        logic [31:0] exp_pc;
        do_reset();
        first = -1;
        first_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (first < 0 && obs_valid) begin
                first = i;
                first_cnt = obs_count;
            end
        end
        n_checks++; if (grant_q.size() < 2 || grant_q[0] !== 32'h0 || grant_q[1] !== 32'h4) begin
            n_errors++; $display("FAIL stream_grants: got n=%0d first=%h expected 0,4", grant_q.size(), grant_q.size() > 0 ? grant_q[0] : 32'hx); end
        n_checks++; if (first !== EXP_FIRST) begin n_errors++; $display("FAIL stream_latency: got cycle %0d expected %0d", first, EXP_FIRST); end
        n_checks++; if (first_cnt !== EXP_FIRST_CNT) begin n_errors++; $display("FAIL stream_first_count: got %0d expected %0d", first_cnt, EXP_FIRST_CNT); end
        n_checks++; if (got_pc.size() !== 8 - EXP_FIRST) begin n_errors++; $display("FAIL stream_consecutive: got %0d delivered expected %0d", got_pc.size(), 8 - EXP_FIRST); end
        for (int k = 0; k < 4; k++) begin
            exp_pc = 32'(k * 4);
            n_checks++; if (got_pc.size() <= k || got_pc[k] !== exp_pc) begin
                n_errors++; $display("FAIL stream_pc%0d: got %h expected %h", k, got_pc.size() > k ? got_pc[k] : 32'hx, exp_pc); end
            n_checks++; if (got_inst.size() <= k || got_inst[k] !== (exp_pc ^ KEY)) begin
                n_errors++; $display("FAIL stream_inst%0d: got %h expected %h", k, got_inst.size() > k ? got_inst[k] : 32'hx, exp_pc ^ KEY); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        inst_ready_in = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (grant_q.size() !== 4) begin n_errors++; $display("FAIL bp_grants: got %0d expected 4", grant_q.size()); end
        n_checks++; if (grant_q.size() < 4 || grant_q[3] !== 32'hC) begin n_errors++; $display("FAIL bp_last_addr: got n=%0d expected addr c", grant_q.size()); end
        n_checks++; if (obs_req !== 1'b0) begin n_errors++; $display("FAIL bp_req: got %0h expected 0", obs_req); end
        n_checks++; if (obs_count !== 3'd4) begin n_errors++; $display("FAIL bp_count: got %0d expected 4", obs_count); end
        n_checks++; if (obs_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid: got %0h expected 1", obs_valid); end
        n_checks++; if (obs_pc !== 32'h0) begin n_errors++; $display("FAIL bp_head_pc: got %h expected 0", obs_pc); end
        inst_ready_in = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (grant_q.size() < 5 || grant_q[4] !== 32'h10) begin
            n_errors++; $display("FAIL bp_resume_addr: got %h expected 10", grant_q.size() > 4 ? grant_q[4] : 32'hx); end
        n_checks++; if (got_pc.size() < 5 || got_pc[3] !== 32'hC || got_pc[4] !== 32'h10) begin
            n_errors++; $display("FAIL bp_resume_seq: got n=%0d pc4=%h expected c,10", got_pc.size(), got_pc.size() > 4 ? got_pc[4] : 32'hx); end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        redirect_pc_in = 32'h100;
        for (int i = 0; i < 12; i++) begin
            rsp_hold = (i == 3 || i == 4);
            redirect_valid_in = (i == 4);
            tick();
            if (i == 4) begin
                n_checks++; if (obs_req !== 1'b0) begin n_errors++; $display("FAIL flush_redirect_req: got %0h expected 0", obs_req); end
                n_checks++; if (obs_valid !== 1'b0) begin n_errors++; $display("FAIL flush_redirect_valid: got %0h expected 0", obs_valid); end
            end
            if (i == 5) begin
                n_checks++; if (obs_count !== 3'd0) begin n_errors++; $display("FAIL flush_count_after: got %0d expected 0", obs_count); end
                n_checks++; if (obs_valid !== 1'b0) begin n_errors++; $display("FAIL flush_valid_after: got %0h expected 0", obs_valid); end
            end
        end
        redirect_valid_in = 1'b0;
        n_checks++; if (grant_q.size() < 5 || grant_q[4] !== 32'h100) begin
            n_errors++; $display("FAIL flush_new_addr: got %h expected 100", grant_q.size() > 4 ? grant_q[4] : 32'hx); end
        n_checks++; if (got_pc.size() < 3 || got_pc[1] !== 32'h4 || got_pc[2] !== 32'h100) begin
            n_errors++; $display("FAIL flush_next_pc: got %h expected 100", got_pc.size() > 2 ? got_pc[2] : 32'hx); end
        n_checks++; if (got_inst.size() < 3 || got_inst[2] !== (32'h100 ^ KEY)) begin
            n_errors++; $display("FAIL flush_next_inst: got %h expected %h", got_inst.size() > 2 ? got_inst[2] : 32'hx, 32'h100 ^ KEY); end
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        redirect_pc_in = 32'h200;
        for (int i = 0; i < 10; i++) begin
            rsp_hold = (i == 2);
            redirect_valid_in = (i == 3);
            tick();
            if (i == 3) begin
                n_checks++; if (obs_valid !== 1'b0) begin n_errors++; $display("FAIL rvredir_valid: got %0h expected 0", obs_valid); end
                n_checks++; if (obs_req !== 1'b0) begin n_errors++; $display("FAIL rvredir_req: got %0h expected 0", obs_req); end
            end
            if (i == 4) begin
                n_checks++; if (obs_count !== 3'd0) begin n_errors++; $display("FAIL rvredir_count: got %0d expected 0", obs_count); end
            end
        end
        redirect_valid_in = 1'b0;
        n_checks++; if (grant_q.size() < 4 || grant_q[3] !== 32'h200) begin
            n_errors++; $display("FAIL rvredir_new_addr: got %h expected 200", grant_q.size() > 3 ? grant_q[3] : 32'hx); end
        n_checks++; if (got_pc.size() < 2 || got_pc[0] !== 32'h0 || got_pc[1] !== 32'h200) begin
            n_errors++; $display("FAIL rvredir_seq: got %h expected 200", got_pc.size() > 1 ? got_pc[1] : 32'hx); end
        n_checks++; if (got_inst.size() < 2 || got_inst[1] !== (32'h200 ^ KEY)) begin
            n_errors++; $display("FAIL rvredir_inst: got %h expected %h", got_inst.size() > 1 ? got_inst[1] : 32'hx, 32'h200 ^ KEY); end
    endtask

    task automatic test_stall_wrap();
        do_reset();
        gnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h0) begin
                n_errors++; $display("FAIL stall_hold%0d: got req=%0h addr=%h expected 1/0", i, obs_req, obs_addr); end
        end
        gnt_en = 1'b1;
        tick();
        redirect_valid_in = 1'b1;
        redirect_pc_in = 32'hFFFF_FFFC;
        tick();
        redirect_valid_in = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        n_checks++; if (grant_q.size() < 3 || grant_q[1] !== 32'hFFFF_FFFC || grant_q[2] !== 32'h0) begin
            n_errors++; $display("FAIL wrap_grants: got %h expected 0 after fffffffc", grant_q.size() > 2 ? grant_q[2] : 32'hx); end
        n_checks++; if (got_pc.size() < 2 || got_pc[0] !== 32'hFFFF_FFFC) begin
            n_errors++; $display("FAIL wrap_pc0: got %h expected fffffffc", got_pc.size() > 0 ? got_pc[0] : 32'hx); end
        n_checks++; if (got_pc.size() < 2 || got_pc[1] !== 32'h0 || got_inst[1] !== KEY) begin
            n_errors++; $display("FAIL wrap_pc1: got %h expected 0", got_pc.size() > 1 ? got_pc[1] : 32'hx); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        rsp_q.delete();
        tick();
        n_checks++; if (obs_req !== 1'b0) begin n_errors++; $display("FAIL midrst_req: got %0h expected 0", obs_req); end
        n_checks++; if (obs_valid !== 1'b0 || obs_count !== 3'd0) begin
            n_errors++; $display("FAIL midrst_fifo: got valid=%0h count=%0d expected 0/0", obs_valid, obs_count); end
        reset = 1'b0;
        clear_logs();
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (grant_q.size() < 1 || grant_q[0] !== 32'h0) begin
            n_errors++; $display("FAIL midrst_addr: got %h expected 0", grant_q.size() > 0 ? grant_q[0] : 32'hx); end
        n_checks++; if (got_pc.size() < 1 || got_pc[0] !== 32'h0) begin
            n_errors++; $display("FAIL midrst_pc: got %h expected 0", got_pc.size() > 0 ? got_pc[0] : 32'hx); end
    endtask

    initial begin
        reset = 1'b1;
        redirect_valid_in = 1'b0;
        redirect_pc_in = '0;
        imem_gnt_in = 1'b0;
        imem_rvalid_in = 1'b0;
        imem_rdata_in = '0;
        inst_ready_in = 1'b1;
        gnt_en = 1'b1;
        rsp_hold = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_rvalid();
        test_stall_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
